// File: rtl/controlador_acceso_parqueo.sv
// Parking gate access controller: PIN entry, wrong-PIN alarm and tailgating block.
// Optional open-gate timeout is enabled by defining TIEMPO_LIMITE_EN.
module controlador_acceso_parqueo #(
  parameter logic [15:0] CLAVE_CORRECTA = 16'h3257,
  parameter int unsigned MAX_INTENTOS   = 3,
  parameter int unsigned TIEMPO_LIMITE  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_llegada_vehiculo,
  input  logic        sensor_ingreso_vehiculo,
  input  logic [15:0] clave_ingresada,
  input  logic        clave_lista,
  output logic        senal_compuerta,
  output logic        senal_alarma_pin,
  output logic        senal_alarma_bloqueo,
  output logic [2:0]  cuenta_intentos
);

  // state      | meaning
  // ESPERA     | idle, gate closed, waiting for a vehicle
  // PIDE_CLAVE | vehicle arrived, waiting for a PIN
  // ABIERTA    | correct PIN accepted, gate open
  // ALARMA_PIN | too many wrong PINs, alarm raised
  // BLOQUEO    | both sensors seen together, locked until correct PIN
  typedef enum logic [2:0] {
    ESPERA,
    PIDE_CLAVE,
    ABIERTA,
    ALARMA_PIN,
    BLOQUEO
  } estado_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_INTENTOS);

  estado_t    estado_q, estado_d;
  logic [2:0] cuenta_q, cuenta_d;
  logic       compuerta_q, compuerta_d;
  logic       alarma_pin_q, alarma_pin_d;
  logic       alarma_bloqueo_q, alarma_bloqueo_d;

  logic       bloqueo_cond;
  logic       clave_ok;
  logic       clave_mal;
  logic       paso_vehiculo;
  logic [2:0] cuenta_inc;

`ifdef TIEMPO_LIMITE_EN
  localparam int TW = (TIEMPO_LIMITE > 1) ? $clog2(TIEMPO_LIMITE) : 1;
  localparam logic [TW-1:0] TIMER_CARGA = TW'(TIEMPO_LIMITE - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    bloqueo_cond  = sensor_llegada_vehiculo & sensor_ingreso_vehiculo;
    clave_ok      = clave_lista & (clave_ingresada == CLAVE_CORRECTA);
    clave_mal     = clave_lista & (clave_ingresada != CLAVE_CORRECTA);
    paso_vehiculo = sensor_ingreso_vehiculo & ~sensor_llegada_vehiculo;
    cuenta_inc    = (cuenta_q == 3'd7) ? 3'd7 : cuenta_q + 3'd1;

    estado_d = estado_q;
    cuenta_d = cuenta_q;
`ifdef TIEMPO_LIMITE_EN
    timer_d  = timer_q;
`endif

    // The block condition overrides every other transition, PIN strobes included.
    if (estado_q != BLOQUEO && bloqueo_cond) begin
      estado_d = BLOQUEO;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (sensor_llegada_vehiculo && !sensor_ingreso_vehiculo) estado_d = PIDE_CLAVE;
        end
        PIDE_CLAVE, ALARMA_PIN: begin
          if (clave_ok) begin
            estado_d = ABIERTA;
            cuenta_d = 3'd0;
`ifdef TIEMPO_LIMITE_EN
            timer_d  = TIMER_CARGA;
`endif
          end else if (clave_mal) begin
            cuenta_d = cuenta_inc;
            if (cuenta_inc >= MAX_CNT) estado_d = ALARMA_PIN;
          end
        end
        ABIERTA: begin
          if (paso_vehiculo) begin
            estado_d = ESPERA;
          end
`ifdef TIEMPO_LIMITE_EN
          else if (timer_q == '0) begin
            estado_d = ESPERA;
          end else begin
            timer_d = timer_q - 1'b1;
          end
`endif
        end
        BLOQUEO: begin
          if (clave_ok) begin
            estado_d = ESPERA;
            cuenta_d = 3'd0;
          end
        end
        default: estado_d = ESPERA;
      endcase
    end

    compuerta_d      = (estado_d == ABIERTA);
    alarma_pin_d     = (estado_d == ALARMA_PIN);
    alarma_bloqueo_d = (estado_d == BLOQUEO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q         <= ESPERA;
      cuenta_q         <= 3'd0;
      compuerta_q      <= 1'b0;
      alarma_pin_q     <= 1'b0;
      alarma_bloqueo_q <= 1'b0;
`ifdef TIEMPO_LIMITE_EN
      timer_q          <= '0;
`endif
    end else begin
      estado_q         <= estado_d;
      cuenta_q         <= cuenta_d;
      compuerta_q      <= compuerta_d;
      alarma_pin_q     <= alarma_pin_d;
      alarma_bloqueo_q <= alarma_bloqueo_d;
`ifdef TIEMPO_LIMITE_EN
      timer_q          <= timer_d;
`endif
    end
  end

  assign senal_compuerta      = compuerta_q;
  assign senal_alarma_pin     = alarma_pin_q;
  assign senal_alarma_bloqueo = alarma_bloqueo_q;
  assign cuenta_intentos      = cuenta_q;

endmodule
